// File: rtl/direction_accumulator_if.sv
// Stream interface between the per-bin direction calculator, the direction accumulator
// and the downstream consumer: per-bin vector beats in, one direction result per frame out.
interface direction_accumulator_if #(
    parameter int BIN_W = 9
) ();
    logic             vec_valid;
    logic             vec_ready;
    logic             vec_last;
    logic [BIN_W-1:0] vec_bin;
    logic [31:0]      vec_data;
    logic             dir_valid;
    logic             dir_ready;
    logic [15:0]      dir_x;
    logic [15:0]      dir_y;
    logic [BIN_W:0]   dir_count;
    logic [2:0]       dir_octant;
    logic             dir_ok;
    logic             dir_sat;

    modport master (
        output vec_valid, vec_last, vec_bin, vec_data, dir_ready,
        input  vec_ready, dir_valid, dir_x, dir_y, dir_count, dir_octant, dir_ok, dir_sat
    );

    modport slave (
        input  vec_valid, vec_last, vec_bin, vec_data, dir_ready,
        output vec_ready, dir_valid, dir_x, dir_y, dir_count, dir_octant, dir_ok, dir_sat
    );
endinterface

// File: rtl/direction_accumulator.sv
// Sums per-bin direction vectors over a bin window and emits one scaled, saturated
// direction vector per frame with bin count, octant and quality flags.
module direction_accumulator #(
    parameter int BIN_W    = 9,
    parameter int BIN_LO   = 4,
    parameter int BIN_HI   = 127,
    parameter int ACC_W    = 28,
    parameter int SHIFT    = 4,
    parameter int MIN_BINS = 8
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    direction_accumulator_if.slave  bus
);
    localparam int CNT_W = BIN_W + 1;

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic               ready_r;
    logic               valid_r;
    logic [ACC_W-1:0]   acc_x_r;
    logic [ACC_W-1:0]   acc_y_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               sat_r;
    logic [15:0]        dir_x_r;
    logic [15:0]        dir_y_r;
    logic [CNT_W-1:0]   dir_count_r;
    logic [2:0]         dir_octant_r;
    logic               dir_ok_r;
    logic               dir_sat_r;

    logic               accept_s;
    logic               in_win_s;
    logic               frame_end_s;
    logic [ACC_W:0]     add_x_s;
    logic [ACC_W:0]     add_y_s;
    logic [ACC_W-1:0]   sum_x_s;
    logic [ACC_W-1:0]   sum_y_s;
    logic [CNT_W-1:0]   cnt_s;
    logic               sat_s;
    logic [16:0]        fmt_x_s;
    logic [16:0]        fmt_y_s;

    // Saturating add of a sign-extended 16-bit sample; MSB of the result flags a clamp.
    function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] acc,
                                               input logic [15:0]      v);
        logic [ACC_W-1:0] ext;
        logic [ACC_W:0]   wide;
        logic [ACC_W:0]   res;
        ext  = {{(ACC_W-16){v[15]}}, v};
        wide = {acc[ACC_W-1], acc} + {ext[ACC_W-1], ext};
        if (wide[ACC_W] != wide[ACC_W-1]) begin
            if (wide[ACC_W]) begin
                res = {1'b1, 1'b1, {(ACC_W-1){1'b0}}};
            end else begin
                res = {1'b1, 1'b0, {(ACC_W-1){1'b1}}};
            end
        end else begin
            res = {1'b0, wide[ACC_W-1:0]};
        end
        return res;
    endfunction

    // Scales a sum down and clamps it to 16 bits; MSB of the result flags a clamp.
    function automatic logic [16:0] fmt_out(input logic [ACC_W-1:0] sum);
        logic [ACC_W-1:0] sh;
        logic [16:0]      res;
        sh = $signed(sum) >>> SHIFT;
        if ((&sh[ACC_W-1:15]) || (~|sh[ACC_W-1:15])) begin
            res = {1'b0, sh[15:0]};
        end else if (sh[ACC_W-1]) begin
            res = {1'b1, 16'h8000};
        end else begin
            res = {1'b1, 16'h7FFF};
        end
        return res;
    endfunction

    // Coarse sector from the signs and the dominant axis of (x, y).
    function automatic logic [2:0] octant(input logic [15:0] x, input logic [15:0] y);
        logic [16:0] xs;
        logic [16:0] ys;
        logic [16:0] ax;
        logic [16:0] ay;
        logic [2:0]  res;
        xs = {x[15], x};
        ys = {y[15], y};
        ax = xs[16] ? (17'd0 - xs) : xs;
        ay = ys[16] ? (17'd0 - ys) : ys;
        case ({y[15], x[15], (ay > ax)})
            3'b000:  res = 3'd0;
            3'b001:  res = 3'd1;
            3'b011:  res = 3'd2;
            3'b010:  res = 3'd3;
            3'b110:  res = 3'd4;
            3'b111:  res = 3'd5;
            3'b101:  res = 3'd6;
            3'b100:  res = 3'd7;
            default: res = 3'd0;
        endcase
        return res;
    endfunction

    assign accept_s    = (state_r == ST_ACCUM) && bus.vec_valid;
    assign in_win_s    = (bus.vec_bin >= BIN_W'(BIN_LO)) && (bus.vec_bin <= BIN_W'(BIN_HI));
    assign frame_end_s = accept_s && bus.vec_last;
    assign add_x_s     = sat_add(acc_x_r, bus.vec_data[15:0]);
    assign add_y_s     = sat_add(acc_y_r, bus.vec_data[31:16]);
    assign fmt_x_s     = fmt_out(sum_x_s);
    assign fmt_y_s     = fmt_out(sum_y_s);

    // Running totals including the beat being accepted this cycle.
    always_comb begin
        sum_x_s = acc_x_r;
        sum_y_s = acc_y_r;
        cnt_s   = cnt_r;
        sat_s   = sat_r;
        if (accept_s && in_win_s) begin
            sum_x_s = add_x_s[ACC_W-1:0];
            sum_y_s = add_y_s[ACC_W-1:0];
            sat_s   = sat_r | add_x_s[ACC_W] | add_y_s[ACC_W];
            if (cnt_r != {CNT_W{1'b1}}) begin
                cnt_s = cnt_r + CNT_W'(1'b1);
            end else begin
                cnt_s = cnt_r;
            end
        end else begin
            sum_x_s = acc_x_r;
            sum_y_s = acc_y_r;
        end
    end

    // Next-state logic: accumulate until a last beat, then hold until the result is taken.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_ACCUM: begin
                if (frame_end_s) begin
                    state_nxt_s = ST_HOLD;
                end else begin
                    state_nxt_s = ST_ACCUM;
                end
            end
            ST_HOLD: begin
                if (bus.dir_ready) begin
                    state_nxt_s = ST_ACCUM;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: state_nxt_s = ST_ACCUM;
        endcase
    end

    // State register with handshake outputs registered alongside it.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_r <= ST_ACCUM;
            ready_r <= 1'b1;
            valid_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            ready_r <= (state_nxt_s == ST_ACCUM);
            valid_r <= (state_nxt_s == ST_HOLD);
        end
    end

    // Accumulators and the frame result registers; totals restart after each frame.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            acc_x_r      <= {ACC_W{1'b0}};
            acc_y_r      <= {ACC_W{1'b0}};
            cnt_r        <= {CNT_W{1'b0}};
            sat_r        <= 1'b0;
            dir_x_r      <= 16'h0000;
            dir_y_r      <= 16'h0000;
            dir_count_r  <= {CNT_W{1'b0}};
            dir_octant_r <= 3'd0;
            dir_ok_r     <= 1'b0;
            dir_sat_r    <= 1'b0;
        end else if (frame_end_s) begin
            acc_x_r      <= {ACC_W{1'b0}};
            acc_y_r      <= {ACC_W{1'b0}};
            cnt_r        <= {CNT_W{1'b0}};
            sat_r        <= 1'b0;
            dir_x_r      <= fmt_x_s[15:0];
            dir_y_r      <= fmt_y_s[15:0];
            dir_count_r  <= cnt_s;
            dir_octant_r <= octant(fmt_x_s[15:0], fmt_y_s[15:0]);
            dir_ok_r     <= (cnt_s >= CNT_W'(MIN_BINS));
            dir_sat_r    <= sat_s | fmt_x_s[16] | fmt_y_s[16];
        end else if (accept_s) begin
            acc_x_r <= sum_x_s;
            acc_y_r <= sum_y_s;
            cnt_r   <= cnt_s;
            sat_r   <= sat_s;
        end else begin
            acc_x_r <= acc_x_r;
            acc_y_r <= acc_y_r;
        end
    end

    assign bus.vec_ready  = ready_r;
    assign bus.dir_valid  = valid_r;
    assign bus.dir_x      = dir_x_r;
    assign bus.dir_y      = dir_y_r;
    assign bus.dir_count  = dir_count_r;
    assign bus.dir_octant = dir_octant_r;
    assign bus.dir_ok     = dir_ok_r;
    assign bus.dir_sat    = dir_sat_r;
endmodule
